// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter sharing one core-to-memory bus between instruction fetch and load/store.
// Data side has priority unless fetch has been starved for STARVE_LIMIT data grants.
module mem_bus_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ireq_valid,
    input  logic [ADDR_W-1:0] ireq_addr,
    output logic              iresp_data_ok,
    output logic [31:0]       iresp_data,
    input  logic              dreq_valid,
    input  logic [ADDR_W-1:0] dreq_addr,
    input  logic [2:0]        dreq_size,
    input  logic [7:0]        dreq_strobe,
    input  logic [63:0]       dreq_data,
    output logic              dresp_data_ok,
    output logic [63:0]       dresp_data,
    output logic              creq_valid,
    output logic              creq_is_write,
    output logic [ADDR_W-1:0] creq_addr,
    output logic [2:0]        creq_size,
    output logic [7:0]        creq_strobe,
    output logic [63:0]       creq_data,
    input  logic              cresp_ok,
    input  logic [63:0]       cresp_data
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t              state_q;
    logic                owner_live_q;
    logic [CNT_W-1:0]    starve_cnt_q;
    logic [CNT_W-1:0]    starve_cnt_d;
    logic                creq_valid_q;
    logic                creq_is_write_q;
    logic [ADDR_W-1:0]   creq_addr_q;
    logic [2:0]          creq_size_q;
    logic [7:0]          creq_strobe_q;
    logic [63:0]         creq_data_q;
    logic                at_limit_s;
    logic                grant_i_s;
    logic                grant_d_s;

    assign at_limit_s = (starve_cnt_q == CNT_W'(STARVE_LIMIT));
    assign grant_i_s  = ireq_valid & (~dreq_valid | at_limit_s);
    assign grant_d_s  = dreq_valid & ~grant_i_s;

    // Starvation counter next value: only arbitration in IDLE moves it.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (state_q == IDLE) begin
            if (grant_i_s) begin
                starve_cnt_d = '0;
            end else if (grant_d_s && ireq_valid && !at_limit_s) begin
                starve_cnt_d = starve_cnt_q + CNT_W'(1);
            end else begin
                starve_cnt_d = starve_cnt_q;
            end
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
    end

    // Arbitration FSM with registered bus request; creq_* stay frozen while BUSY.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q         <= IDLE;
            owner_live_q    <= 1'b0;
            starve_cnt_q    <= '0;
            creq_valid_q    <= 1'b0;
            creq_is_write_q <= 1'b0;
            creq_addr_q     <= '0;
            creq_size_q     <= 3'b000;
            creq_strobe_q   <= 8'h00;
            creq_data_q     <= 64'h0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            case (state_q)
                IDLE: begin
                    if (grant_d_s) begin
                        state_q         <= BUSY_D;
                        owner_live_q    <= 1'b1;
                        creq_valid_q    <= 1'b1;
                        creq_is_write_q <= |dreq_strobe;
                        creq_addr_q     <= dreq_addr;
                        creq_size_q     <= dreq_size;
                        creq_strobe_q   <= dreq_strobe;
                        creq_data_q     <= dreq_data;
                    end else if (grant_i_s) begin
                        state_q         <= BUSY_I;
                        owner_live_q    <= 1'b1;
                        creq_valid_q    <= 1'b1;
                        creq_is_write_q <= 1'b0;
                        creq_addr_q     <= ireq_addr;
                        creq_size_q     <= 3'b010;
                        creq_strobe_q   <= 8'h00;
                        creq_data_q     <= 64'h0;
                    end else begin
                        state_q      <= IDLE;
                        owner_live_q <= 1'b0;
                        creq_valid_q <= 1'b0;
                    end
                end
                BUSY_I: begin
                    if (cresp_ok) begin
                        state_q      <= IDLE;
                        owner_live_q <= 1'b0;
                        creq_valid_q <= 1'b0;
                    end else if (!ireq_valid) begin
                        owner_live_q <= 1'b0;
                    end else begin
                        owner_live_q <= owner_live_q;
                    end
                end
                BUSY_D: begin
                    if (cresp_ok) begin
                        state_q      <= IDLE;
                        owner_live_q <= 1'b0;
                        creq_valid_q <= 1'b0;
                    end else if (!dreq_valid) begin
                        owner_live_q <= 1'b0;
                    end else begin
                        owner_live_q <= owner_live_q;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    owner_live_q <= 1'b0;
                    creq_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign creq_valid    = creq_valid_q;
    assign creq_is_write = creq_is_write_q;
    assign creq_addr     = creq_addr_q;
    assign creq_size     = creq_size_q;
    assign creq_strobe   = creq_strobe_q;
    assign creq_data     = creq_data_q;

    // A flushed owner (owner_live_q low) never sees its response.
    assign iresp_data_ok = (state_q == BUSY_I) & cresp_ok & owner_live_q;
    assign dresp_data_ok = (state_q == BUSY_D) & cresp_ok & owner_live_q;
    assign iresp_data    = creq_addr_q[2] ? cresp_data[63:32] : cresp_data[31:0];
    assign dresp_data    = cresp_data;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter: inputs driven and outputs sampled at negedge.
module tb_mem_bus_arbiter;

    logic        clk;
    logic        reset;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        dreq_valid;
    logic [63:0] dreq_addr;
    logic [2:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;
    logic        dresp_data_ok;
    logic [63:0] dresp_data;
    logic        creq_valid;
    logic        creq_is_write;
    logic [63:0] creq_addr;
    logic [2:0]  creq_size;
    logic [7:0]  creq_strobe;
    logic [63:0] creq_data;
    logic        cresp_ok;
    logic [63:0] cresp_data;

    int checks = 0;
    int errors = 0;

    mem_bus_arbiter #(.STARVE_LIMIT(4), .ADDR_W(64)) dut (
        .clk(clk), .reset(reset),
        .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
        .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
        .creq_valid(creq_valid), .creq_is_write(creq_is_write), .creq_addr(creq_addr),
        .creq_size(creq_size), .creq_strobe(creq_strobe), .creq_data(creq_data),
        .cresp_ok(cresp_ok), .cresp_data(cresp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_creq(input string tag);
        int n = 0;
        while (creq_valid !== 1'b1 && n < 12) begin
            tick();
            n++;
        end
        check({tag, " creq_valid"}, {63'd0, creq_valid}, 64'd1);
    endtask

    initial begin
        logic [63:0] rd;
        reset = 1'b0; ireq_valid = 1'b0; ireq_addr = 64'h0;
        dreq_valid = 1'b0; dreq_addr = 64'h0; dreq_size = 3'd0; dreq_strobe = 8'h00;
        dreq_data = 64'h0; cresp_ok = 1'b0; cresp_data = 64'h0;

        // Reset then idle
        @(negedge clk);
        tick(); tick();
        check("rst creq_valid", {63'd0, creq_valid}, 64'd0);
        check("rst iresp_ok", {63'd0, iresp_data_ok}, 64'd0);
        check("rst dresp_ok", {63'd0, dresp_data_ok}, 64'd0);
        check("rst creq_addr", creq_addr, 64'd0);
        reset = 1'b1;
        tick(); tick();
        check("idle no grant", {63'd0, creq_valid}, 64'd0);

        // Single fetch, odd word selects upper half
        ireq_valid = 1'b1; ireq_addr = 64'h0000_0000_8000_0004;
        tick();
        check("fetch creq_valid", {63'd0, creq_valid}, 64'd1);
        check("fetch creq_addr", creq_addr, 64'h0000_0000_8000_0004);
        check("fetch creq_size", {61'd0, creq_size}, 64'd2);
        check("fetch creq_strobe", {56'd0, creq_strobe}, 64'd0);
        check("fetch is_write", {63'd0, creq_is_write}, 64'd0);
        tick(); tick(); tick();
        check("fetch held", creq_addr, 64'h0000_0000_8000_0004);
        check("fetch no early ok", {63'd0, iresp_data_ok}, 64'd0);
        cresp_ok = 1'b1; cresp_data = 64'h1111_2222_3333_4444;
        #1;
        check("fetch iresp_ok", {63'd0, iresp_data_ok}, 64'd1);
        check("fetch iresp_data", {32'd0, iresp_data}, 64'h1111_2222);
        check("fetch no dresp", {63'd0, dresp_data_ok}, 64'd0);
        tick();
        cresp_ok = 1'b0; ireq_valid = 1'b0;
        #1;
        check("fetch pulse once", {63'd0, iresp_data_ok}, 64'd0);
        check("fetch idle", {63'd0, creq_valid}, 64'd0);
        tick();
        check("fetch no regrant", {63'd0, creq_valid}, 64'd0);

        // Simultaneous: data store first, fetch after a one-cycle bubble
        ireq_valid = 1'b1; ireq_addr = 64'h1000;
        dreq_valid = 1'b1; dreq_addr = 64'h2000; dreq_size = 3'd3;
        dreq_strobe = 8'h0F; dreq_data = 64'hDEAD_BEEF_CAFE_F00D;
        tick();
        check("sim data granted", creq_addr, 64'h2000);
        check("sim is_write", {63'd0, creq_is_write}, 64'd1);
        check("sim strobe", {56'd0, creq_strobe}, 64'h0F);
        check("sim wdata", creq_data, 64'hDEAD_BEEF_CAFE_F00D);
        check("sim size", {61'd0, creq_size}, 64'd3);
        tick();
        cresp_ok = 1'b1; cresp_data = 64'h5;
        dreq_valid = 1'b0;
        #1;
        check("sim dresp_ok same-cycle drop", {63'd0, dresp_data_ok}, 64'd1);
        check("sim no iresp", {63'd0, iresp_data_ok}, 64'd0);
        tick();
        cresp_ok = 1'b0;
        check("sim bubble", {63'd0, creq_valid}, 64'd0);
        tick();
        check("sim fetch creq_valid M+2", {63'd0, creq_valid}, 64'd1);
        check("sim fetch addr", creq_addr, 64'h1000);
        check("sim fetch is_write", {63'd0, creq_is_write}, 64'd0);
        cresp_ok = 1'b1; cresp_data = 64'hAAAA_AAAA_BBBB_BBBB;
        ireq_valid = 1'b0;
        #1;
        check("sim iresp_ok", {63'd0, iresp_data_ok}, 64'd1);
        check("sim iresp_data low", {32'd0, iresp_data}, 64'hBBBB_BBBB);
        tick();
        cresp_ok = 1'b0;

        // Starvation: D,D,D,D then I, then D once fetch drops
        ireq_valid = 1'b1; ireq_addr = 64'h4000;
        dreq_valid = 1'b1; dreq_addr = 64'h3000; dreq_strobe = 8'h00; dreq_size = 3'd3;
        for (int i = 0; i < 6; i++) begin
            wait_creq($sformatf("starve%0d", i));
            check($sformatf("starve%0d addr", i), creq_addr, (i == 4) ? 64'h4000 : 64'h3000);
            if (i == 3) check("starve cnt at limit", {61'd0, dut.starve_cnt_q}, 64'd4);
            rd = 64'h0100_0000_0000_0010 * (i + 1);
            cresp_ok = 1'b1; cresp_data = rd;
            #1;
            if (i == 4) begin
                check("starve fetch ok", {63'd0, iresp_data_ok}, 64'd1);
                check("starve fetch data", {32'd0, iresp_data}, {32'd0, rd[31:0]});
                ireq_valid = 1'b0;
            end else begin
                check($sformatf("starve%0d dresp_ok", i), {63'd0, dresp_data_ok}, 64'd1);
                check($sformatf("starve%0d dresp_data", i), dresp_data, rd);
                if (i == 5) dreq_valid = 1'b0;
            end
            tick();
            cresp_ok = 1'b0;
        end
        check("starve cnt cleared", {61'd0, dut.starve_cnt_q}, 64'd0);

        // Flush: data owner drops valid after grant, bus keeps request, response dropped
        dreq_valid = 1'b1; dreq_addr = 64'h5000; dreq_strobe = 8'hFF; dreq_data = 64'h1234;
        tick();
        check("flush creq_valid", {63'd0, creq_valid}, 64'd1);
        dreq_valid = 1'b0; dreq_addr = 64'h6000; dreq_strobe = 8'h00;
        tick(); tick();
        check("flush held valid", {63'd0, creq_valid}, 64'd1);
        check("flush held addr", creq_addr, 64'h5000);
        check("flush held strobe", {56'd0, creq_strobe}, 64'hFF);
        cresp_ok = 1'b1; cresp_data = 64'h77;
        #1;
        check("flush no dresp", {63'd0, dresp_data_ok}, 64'd0);
        tick();
        cresp_ok = 1'b0;
        check("flush idle", {63'd0, creq_valid}, 64'd0);
        tick();
        check("flush stays idle", {63'd0, creq_valid}, 64'd0);

        // Reset during BUSY_I abandons transaction
        ireq_valid = 1'b1; ireq_addr = 64'h7004;
        tick();
        check("rstmid busy", {63'd0, creq_valid}, 64'd1);
        reset = 1'b0; ireq_valid = 1'b0;
        tick();
        check("rstmid creq_valid", {63'd0, creq_valid}, 64'd0);
        check("rstmid creq_addr", creq_addr, 64'd0);
        cresp_ok = 1'b1; cresp_data = 64'h99;
        #1;
        check("rstmid no iresp", {63'd0, iresp_data_ok}, 64'd0);
        tick();
        reset = 1'b1; cresp_ok = 1'b0;
        tick();
        check("rstmid stays idle", {63'd0, creq_valid}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single core-to-memory bus (cbus) between the fetch port (ireq/iresp) and the load/store port (dreq/dresp).
- Sits between the pipeline front end / memory stage and the cache/bus interface.
- The hazard unit already consumes ireq_valid/iresp_data_ok and dreq_valid/dresp_data_ok, so the stall logic is unchanged.
- Serializes requests, holds each bus request stable until it completes, and routes each response back to the requester that owns it.

Parameters:
- STARVE_LIMIT, 4: consecutive data-side grants made while ireq_valid was pending, after which fetch is granted first.
- ADDR_W, 64: address width.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-low reset (0 = reset)
- ireq_valid  input  1  fetch request
- ireq_addr  input  ADDR_W  fetch address, 4-byte aligned
- iresp_data_ok  output  1  fetch response valid, single-cycle pulse
- iresp_data  output  32  instruction word
- dreq_valid  input  1  data request
- dreq_addr  input  ADDR_W  data address
- dreq_size  input  3  log2 of byte count
- dreq_strobe  input  8  byte write enables; all zero means read
- dreq_data  input  64  write data
- dresp_data_ok  output  1  data response valid, single-cycle pulse
- dresp_data  output  64  read data
- creq_valid  output  1  bus request
- creq_is_write  output  1  bus write
- creq_addr  output  ADDR_W  bus address
- creq_size  output  3  bus size
- creq_strobe  output  8  bus strobes
- creq_data  output  64  bus write data
- cresp_ok  input  1  bus completion, single cycle
- cresp_data  input  64  bus read data

Behaviour:
- States: IDLE, BUSY_I, BUSY_D. An owner_live flag is used in both BUSY states.
- Reset (reset==0 at a clk edge): state=IDLE, starve_cnt=0, all creq_* registers 0. iresp_data_ok, dresp_data_ok, creq_valid are 0 in the following cycle. Reset applies mid-transaction too: the pending bus transaction is abandoned and no response is forwarded.
- IDLE grant:
  - Only dreq_valid: go to BUSY_D.
  - Only ireq_valid: go to BUSY_I.
  - Both: data wins unless starve_cnt==STARVE_LIMIT, in which case fetch wins.
- Latch at grant: creq_addr/size/strobe/data and is_write are latched. creq_is_write = |dreq_strobe. A fetch latches size=3'b010, strobe=0, is_write=0. Set owner_live=1.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) on each data grant made while ireq_valid=1.
  - Clears on any fetch grant.
  - Unchanged on a data grant while ireq_valid=0.
- Bus request: creq_valid=1 in every BUSY cycle. It rises the cycle after the grant edge. creq_* are registered and hold stable until cresp_ok.
- Completion: cresp_ok=1 in a BUSY state returns to IDLE at the next edge.
- Response routing (combinational, same cycle as cresp_ok):
  - BUSY_D: dresp_data_ok = cresp_ok & owner_live; dresp_data = cresp_data.
  - BUSY_I: iresp_data_ok = cresp_ok & owner_live; iresp_data = creq_addr[2] ? cresp_data[63:32] : cresp_data[31:0].
- Abort (flush): owner drops its valid while BUSY and cresp_ok=0. Clear owner_live. The bus transaction still runs to cresp_ok with creq_* unchanged, and its response is discarded (no data_ok pulse).
- Abort in the same cycle as cresp_ok: the response is still forwarded.
- Pipelining: completion at cycle M means IDLE at M+1, which may grant again. The next creq_valid is at M+2, so there is a 1-cycle bus bubble; no back-to-back bus requests.
- A requester whose valid stays high after its data_ok is treated as a new request in IDLE.
- iresp/dresp data_ok are never asserted outside a BUSY state, and never both in one cycle.

Test Plan:
- Reset then idle: assert reset=0 for 2 cycles, release -> creq_valid=0, both data_ok=0, no grant with both valids low.
- Single fetch: ireq_addr=0x80000004, cresp_ok 3 cycles after creq_valid with cresp_data=0x11112222_33334444 -> iresp_data=0x11112222 with one iresp_data_ok pulse; creq_size=2, creq_strobe=0.
- Simultaneous requests: both valid, data store strobe=0x0F -> data granted first (creq_is_write=1). After its cresp_ok, fetch is granted; its creq_valid is 2 cycles after the first cresp_ok.
- Starvation: ireq_valid held, dreq_valid held for 6 transactions, STARVE_LIMIT=4 -> 4 data grants, then a fetch grant, and starve_cnt=0 afterwards.
- Flush mid-transaction: drop dreq_valid 1 cycle after the grant -> creq_* held until cresp_ok, dresp_data_ok stays 0, state returns to IDLE.
- Reset mid-transaction: reset=0 while in BUSY_I -> creq_valid=0 next cycle, no iresp_data_ok even if cresp_ok arrives.
